// File: rtl/bib3_pkg.sv
// bib3_pkg: definitions shared by the bib3 execution unit and its sequencing
// driver bib3_surucu.
//   - Field widths of the 9-bit instruction word {op, a, b} and of the 4-bit result.
//   - Bit positions of each field inside the instruction word.
//   - Driver FSM state encoding.
package bib3_pkg;

    localparam int OP_W     = 3;
    localparam int A_W      = 3;
    localparam int B_W      = 3;
    localparam int BUYRUK_W = OP_W + A_W + B_W;
    localparam int SONUC_W  = 4;

    // Field slices inside a buyruk word: {op[8:6], a[5:3], b[2:0]}.
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int A_MSB  = 5;
    localparam int A_LSB  = 3;
    localparam int B_MSB  = 2;
    localparam int B_LSB  = 0;

    typedef logic [BUYRUK_W-1:0] buyruk_t;
    typedef logic [SONUC_W-1:0]  sonuc_t;

    // BOS: idle, CALIS: issuing instructions, BITTI: one-cycle completion.
    typedef enum logic [1:0] {
        BOS   = 2'd0,
        CALIS = 2'd1,
        BITTI = 2'd2
    } durum_e;

endpackage

// File: rtl/bib3_surucu_if.sv
// bib3_surucu_if: instruction/result link between the driver and bib3.
//   buyruk : instruction word presented to bib3 (driver -> bib3).
//   sonuc  : result from bib3, combinational from buyruk (bib3 -> driver).
// Modports: master = driver side, slave = bib3 side.
interface bib3_surucu_if;
    import bib3_pkg::*;

    buyruk_t buyruk;
    sonuc_t  sonuc;

    modport master (output buyruk, input sonuc);
    modport slave  (input buyruk, output sonuc);

endinterface

// File: rtl/bib3_surucu_buyruk_bellek.sv
// buyruk_bellek: DERINLIK x 9-bit program store for bib3_surucu.
//   clk, rst_n : clock, asynchronous active-low clear of every slot.
//   yaz_en_i   : write strobe (qualified by the caller).
//   yaz_adr_i  : slot to write.
//   yaz_veri_i : instruction word to store.
//   oku_adr_i  : slot to read.
//   oku_veri_o : combinational read of slot oku_adr_i.
module buyruk_bellek
    import bib3_pkg::*;
#(
    parameter  int DERINLIK = 8,
    localparam int ADR_W    = $clog2(DERINLIK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             yaz_en_i,
    input  logic [ADR_W-1:0] yaz_adr_i,
    input  buyruk_t          yaz_veri_i,
    input  logic [ADR_W-1:0] oku_adr_i,
    output buyruk_t          oku_veri_o
);

    buyruk_t bellek_q [DERINLIK];

    // NOTE: this store is a plain register file, so every slot is cleared by
    // reset; a run started right after reset must see all-zero words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DERINLIK; i++) begin
                bellek_q[i] <= '0;
            end
        end else if (yaz_en_i) begin
            bellek_q[yaz_adr_i] <= yaz_veri_i;
        end
    end

    assign oku_veri_o = bellek_q[oku_adr_i];

endmodule

// File: rtl/bib3_surucu.sv
// bib3_surucu: sequencing driver for the bib3 execution unit.
// Holds a program of 9-bit instructions, issues them one at a time for
// BEKLEME cycles each, and captures bib3's 4-bit result for every issued
// instruction into a result buffer.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   yaz_en      : program write strobe (ignored while mesgul).
//   yaz_adr     : program slot to write.
//   yaz_buyruk  : instruction word {op, a, b}.
//   baslat      : start a run (sampled in BOS only).
//   adet        : number of instructions to run from slot 0, clamped to DERINLIK.
//   oku_adr     : result slot to read.
//   oku_sonuc   : combinational read of result slot oku_adr.
//   mesgul      : run in progress (state != BOS).
//   bitti       : one-cycle completion pulse.
//   bus         : master side of the bib3 link (registered buyruk out, sonuc in).
module bib3_surucu
    import bib3_pkg::*;
#(
    parameter  int DERINLIK = 8,
    parameter  int BEKLEME  = 2,
    localparam int ADR_W    = $clog2(DERINLIK),
    localparam int ADET_W   = ADR_W + 1,
    localparam int SAY_W    = (BEKLEME > 1) ? $clog2(BEKLEME) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              yaz_en,
    input  logic [ADR_W-1:0]  yaz_adr,
    input  buyruk_t           yaz_buyruk,
    input  logic              baslat,
    input  logic [ADET_W-1:0] adet,
    input  logic [ADR_W-1:0]  oku_adr,
    output sonuc_t            oku_sonuc,
    output logic              mesgul,
    output logic              bitti,
    bib3_surucu_if.master     bus
);

    durum_e            durum_q, durum_d;
    logic [ADR_W-1:0]  idx_q, idx_d;
    logic [ADR_W-1:0]  son_q, son_d;     // index of the last instruction of this run
    logic [SAY_W-1:0]  say_q, say_d;     // hold counter, 0..BEKLEME-1
    buyruk_t           buyruk_q, buyruk_d;
    sonuc_t            sonuc_q [DERINLIK];

    logic              yakala;           // capture bus.sonuc into result[idx_q] this edge
    logic [ADR_W-1:0]  prog_adr;
    buyruk_t           prog_veri;
    logic [ADET_W-1:0] adet_kisit;

    // The program is frozen while a run is in progress.
    buyruk_bellek #(.DERINLIK(DERINLIK)) u_bellek (
        .clk        (clk),
        .rst_n      (rst_n),
        .yaz_en_i   (yaz_en && (durum_q == BOS)),
        .yaz_adr_i  (yaz_adr),
        .yaz_veri_i (yaz_buyruk),
        .oku_adr_i  (prog_adr),
        .oku_veri_o (prog_veri)
    );

    // adet larger than the program is clamped rather than wrapped.
    assign adet_kisit = (adet > ADET_W'(DERINLIK)) ? ADET_W'(DERINLIK) : adet;

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        durum_d  = durum_q;
        idx_d    = idx_q;
        son_d    = son_q;
        say_d    = say_q;
        buyruk_d = buyruk_q;
        yakala   = 1'b0;
        prog_adr = '0;

        unique case (durum_q)
            BOS: begin
                buyruk_d = '0;
                if (baslat) begin
                    if (adet == '0) begin
                        durum_d = BITTI;
                    end else begin
                        durum_d  = CALIS;
                        idx_d    = '0;
                        say_d    = '0;
                        son_d    = ADR_W'(adet_kisit - 1'b1);
                        buyruk_d = prog_veri;   // prog_adr is 0 here
                    end
                end
            end
            CALIS: begin
                // Prefetch the next word so it can be loaded on the last hold edge.
                prog_adr = idx_q + 1'b1;
                if (say_q == SAY_W'(BEKLEME - 1)) begin
                    yakala = 1'b1;
                    if (idx_q == son_q) begin
                        durum_d  = BITTI;
                        buyruk_d = '0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        say_d    = '0;
                        buyruk_d = prog_veri;
                    end
                end else begin
                    say_d = say_q + 1'b1;
                end
            end
            BITTI: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q  <= BOS;
            idx_q    <= '0;
            son_q    <= '0;
            say_q    <= '0;
            buyruk_q <= '0;
        end else begin
            durum_q  <= durum_d;
            idx_q    <= idx_d;
            son_q    <= son_d;
            say_q    <= say_d;
            buyruk_q <= buyruk_d;
        end
    end

    // Result buffer: a reset mid-run clears it and drops any pending capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DERINLIK; i++) begin
                sonuc_q[i] <= '0;
            end
        end else if (yakala) begin
            sonuc_q[idx_q] <= bus.sonuc;
        end
    end

    // A read colliding with a capture to the same slot returns the old value.
    assign oku_sonuc  = sonuc_q[oku_adr];
    assign bus.buyruk = buyruk_q;
    assign mesgul     = (durum_q != BOS);
    assign bitti      = (durum_q == BITTI);

endmodule

// File: tb/tb_bib3_surucu.sv
// Testbench for bib3_surucu. Two instances share all stimulus: one with
// BEKLEME=2, one with BEKLEME=1. Each has a stand-in bib3 model on its link.
// Expected per-cycle outputs of a run go into a queue when the run is
// started; a negedge monitor pops one entry for every busy cycle.
module tb_bib3_surucu;
    import bib3_pkg::*;

    localparam int DERINLIK = 8;

    typedef struct packed {
        buyruk_t buyruk;
        logic    bitti;
    } beklenen_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       yaz_en = 1'b0;
    logic [2:0] yaz_adr = '0;
    buyruk_t    yaz_buyruk = '0;
    logic       baslat = 1'b0;
    logic [3:0] adet = '0;
    logic [2:0] oku_adr = '0;

    sonuc_t oku_sonuc_b2, oku_sonuc_b1;
    logic   mesgul_b2, mesgul_b1, bitti_b2, bitti_b1;

    bib3_surucu_if bus_b2 ();
    bib3_surucu_if bus_b1 ();

    beklenen_t q_b2[$];
    beklenen_t q_b1[$];
    buyruk_t   prog_m [DERINLIK];
    sonuc_t    res_b2_m [DERINLIK];
    sonuc_t    res_b1_m [DERINLIK];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in for bib3: combinational result from the instruction word.
    function automatic sonuc_t bib3_model(input buyruk_t w);
        logic [2:0] op, a, b;
        op = w[OP_MSB:OP_LSB];
        a  = w[A_MSB:A_LSB];
        b  = w[B_MSB:B_LSB];
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a | b};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, a} + 4'd1;
            3'd6:    return {1'b0, b} - {1'b0, a};
            default: return {1'b1, a};
        endcase
    endfunction

    assign bus_b2.sonuc = bib3_model(bus_b2.buyruk);
    assign bus_b1.sonuc = bib3_model(bus_b1.buyruk);

    bib3_surucu #(.DERINLIK(DERINLIK), .BEKLEME(2)) dut_b2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .yaz_en     (yaz_en),
        .yaz_adr    (yaz_adr),
        .yaz_buyruk (yaz_buyruk),
        .baslat     (baslat),
        .adet       (adet),
        .oku_adr    (oku_adr),
        .oku_sonuc  (oku_sonuc_b2),
        .mesgul     (mesgul_b2),
        .bitti      (bitti_b2),
        .bus        (bus_b2.master)
    );

    bib3_surucu #(.DERINLIK(DERINLIK), .BEKLEME(1)) dut_b1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .yaz_en     (yaz_en),
        .yaz_adr    (yaz_adr),
        .yaz_buyruk (yaz_buyruk),
        .baslat     (baslat),
        .adet       (adet),
        .oku_adr    (oku_adr),
        .oku_sonuc  (oku_sonuc_b1),
        .mesgul     (mesgul_b1),
        .bitti      (bitti_b1),
        .bus        (bus_b1.master)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One monitor step for one instance: busy cycles consume an expected entry.
    task automatic mon(input int m, input logic mes, input logic bit_o, input buyruk_t b);
        beklenen_t e;
        int        n;
        n = (m == 2) ? q_b2.size() : q_b1.size();
        if (mes) begin
            if (n == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_busy_b%0d: mesgul=1 buyruk=0x%0h bitti=%0b, expected idle (t=%0t)",
                         m, b, bit_o, $time);
            end else begin
                if (m == 2) e = q_b2.pop_front();
                else        e = q_b1.pop_front();
                check($sformatf("buyruk_b%0d", m), b, e.buyruk);
                check($sformatf("bitti_b%0d", m), bit_o, e.bitti);
            end
        end else begin
            check($sformatf("idle_buyruk_b%0d", m), b, 0);
            check($sformatf("idle_bitti_b%0d", m), bit_o, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(2, mesgul_b2, bitti_b2, bus_b2.buyruk);
        mon(1, mesgul_b1, bitti_b1, bus_b1.buyruk);
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic write_prog(input int adr, input buyruk_t w);
        yaz_en     = 1'b1;
        yaz_adr    = 3'(adr);
        yaz_buyruk = w;
        prog_m[adr] = w;
        @(posedge clk);
        #1;
        yaz_en = 1'b0;
    endtask

    task automatic push_exp(input int n);
        int nn;
        nn = (n > DERINLIK) ? DERINLIK : n;
        for (int k = 0; k < nn; k++) begin
            repeat (2) q_b2.push_back('{buyruk: prog_m[k], bitti: 1'b0});
            q_b1.push_back('{buyruk: prog_m[k], bitti: 1'b0});
            res_b2_m[k] = bib3_model(prog_m[k]);
            res_b1_m[k] = bib3_model(prog_m[k]);
        end
        q_b2.push_back('{buyruk: '0, bitti: 1'b1});
        q_b1.push_back('{buyruk: '0, bitti: 1'b1});
    endtask

    // Returns in cycle t+1, where t is the cycle in which baslat was sampled.
    task automatic start_run(input int n);
        baslat = 1'b1;
        adet   = 4'(n);
        push_exp(n);
        @(posedge clk);
        #1;
        baslat = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q_b2.size() != 0 || q_b1.size() != 0) && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        check("run_completes", q_b2.size() + q_b1.size(), 0);
        q_b2.delete();
        q_b1.delete();
        #1;
    endtask

    task automatic readback();
        for (int i = 0; i < DERINLIK; i++) begin
            oku_adr = 3'(i);
            #1;
            check($sformatf("result_b2[%0d]", i), oku_sonuc_b2, res_b2_m[i]);
            check($sformatf("result_b1[%0d]", i), oku_sonuc_b1, res_b1_m[i]);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < DERINLIK; i++) begin
            prog_m[i]   = '0;
            res_b2_m[i] = '0;
            res_b1_m[i] = '0;
        end
    endtask

    task automatic load_full_prog();
        write_prog(0, 9'b000_011_001);
        write_prog(1, 9'b001_011_001);
        for (int k = 2; k < DERINLIK; k++) begin
            write_prog(k, {3'(k), 6'b010_101});
        end
    endtask

    sonuc_t old_v;

    initial begin
        clear_models();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mesgul_b2", mesgul_b2, 0);
        check("rst_mesgul_b1", mesgul_b1, 0);
        check("rst_buyruk_b2", bus_b2.buyruk, 0);
        check("rst_bitti_b1", bitti_b1, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        readback();

        // Single run: 9'h019 for one instruction.
        write_prog(0, 9'h019);
        start_run(1);
        drain();
        readback();
        check("single_result0_b2", res_b2_m[0], 4'd4);

        // Full program, 8 instructions.
        load_full_prog();
        start_run(8);
        drain();
        readback();

        // Clamp: adet=12 issues exactly 8.
        start_run(12);
        drain();
        readback();

        // Zero: change prog[0] so an erroneous issue would alter result[0].
        write_prog(0, 9'h1FF);
        start_run(0);
        drain();
        readback();
        write_prog(0, 9'b000_011_001);

        // Ignored write and baslat while busy (both instances busy at t+2).
        start_run(8);
        @(posedge clk);
        #1;
        yaz_en     = 1'b1;
        yaz_adr    = 3'd0;
        yaz_buyruk = 9'h0AA;
        baslat     = 1'b1;
        adet       = 4'd8;
        @(posedge clk);
        #1;
        yaz_en = 1'b0;
        baslat = 1'b0;
        drain();
        start_run(1);
        drain();
        readback();

        // Mid-run reset during instruction 3 of the BEKLEME=2 instance.
        start_run(8);
        repeat (6) @(posedge clk);
        #1;
        check("prereset_buyruk_b2", bus_b2.buyruk, prog_m[3]);
        rst_n = 1'b0;
        q_b2.delete();
        q_b1.delete();
        clear_models();
        #1;
        check("midrst_buyruk_b2", bus_b2.buyruk, 0);
        check("midrst_mesgul_b2", mesgul_b2, 0);
        check("midrst_buyruk_b1", bus_b1.buyruk, 0);
        check("midrst_mesgul_b1", mesgul_b1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        readback();

        // New run after reset, with oku_adr=2 held to observe the collision.
        load_full_prog();
        oku_adr = 3'd2;
        old_v   = res_b2_m[2];
        start_run(8);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 3) check("collide_old_b1", oku_sonuc_b1, old_v);
            if (c == 4) check("collide_new_b1", oku_sonuc_b1, res_b1_m[2]);
            if (c == 6) check("collide_old_b2", oku_sonuc_b2, old_v);
            if (c == 7) check("collide_new_b2", oku_sonuc_b2, res_b2_m[2]);
        end
        @(posedge clk);
        #1;
        drain();
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
